// File: rtl/t_c.sv
// Two-way traffic-light controller: four-phase Moore FSM with a cycle timer and
// latched emergency requests that force an extended green at the next safe point.
module t_c #(
    parameter int GREEN_CYCLES  = 20,
    parameter int YELLOW_CYCLES = 5,
    parameter int EMG_CYCLES    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       emg_n_s,
    input  logic       emg_e_w,
    output logic [2:0] n_s_light_out,
    output logic [2:0] e_w_light_out
);

    localparam int GE_MAX = (GREEN_CYCLES > EMG_CYCLES) ? GREEN_CYCLES : EMG_CYCLES;
    localparam int T_MAX  = (GE_MAX > YELLOW_CYCLES) ? GE_MAX : YELLOW_CYCLES;
    localparam int TW     = (T_MAX <= 2) ? 1 : $clog2(T_MAX);

    localparam logic [TW-1:0] GRN_END = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] EMG_END = TW'(EMG_CYCLES - 1);
    localparam logic [TW-1:0] YEL_END = TW'(YELLOW_CYCLES - 1);

    localparam logic [2:0] LAMP_G = 3'b001;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_R = 3'b100;

    // One-hot encoding so that corrupted state values are detectable and recover.
    typedef enum logic [3:0] {
        NS_G = 4'b0001,
        NS_Y = 4'b0010,
        EW_G = 4'b0100,
        EW_Y = 4'b1000
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_timer;
    logic            r_emg_mode;
    logic            r_pend_ns;
    logic            r_pend_ew;

    state_t          w_next_state;
    logic            w_timer_clr;
    logic            w_next_emg;
    logic            w_serve_ns;
    logic            w_serve_ew;
    logic            w_grn_done;
    logic            w_yel_done;

    assign w_grn_done = (r_timer == (r_emg_mode ? EMG_END : GRN_END));
    assign w_yel_done = (r_timer == YEL_END);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        w_timer_clr  = 1'b0;
        w_next_emg   = r_emg_mode;
        w_serve_ns   = 1'b0;
        w_serve_ew   = 1'b0;
        case (r_state)
            NS_G: begin
                if (r_pend_ns) begin
                    w_timer_clr = 1'b1;
                    w_next_emg  = 1'b1;
                    w_serve_ns  = 1'b1;
                end else if ((r_pend_ew && !r_emg_mode) || w_grn_done) begin
                    w_next_state = NS_Y;
                    w_timer_clr  = 1'b1;
                end
            end
            EW_G: begin
                // A pending NS request outranks re-extending EW.
                if (r_pend_ew && !r_pend_ns) begin
                    w_timer_clr = 1'b1;
                    w_next_emg  = 1'b1;
                    w_serve_ew  = 1'b1;
                end else if ((r_pend_ns && !r_emg_mode) || w_grn_done) begin
                    w_next_state = EW_Y;
                    w_timer_clr  = 1'b1;
                end
            end
            NS_Y, EW_Y: begin
                if (w_yel_done) begin
                    w_timer_clr = 1'b1;
                    if (r_pend_ns) begin
                        w_next_state = NS_G;
                        w_next_emg   = 1'b1;
                        w_serve_ns   = 1'b1;
                    end else if (r_pend_ew) begin
                        w_next_state = EW_G;
                        w_next_emg   = 1'b1;
                        w_serve_ew   = 1'b1;
                    end else begin
                        w_next_state = (r_state == NS_Y) ? EW_G : NS_G;
                        w_next_emg   = 1'b0;
                    end
                end
            end
            default: begin
                w_next_state = NS_G;
                w_timer_clr  = 1'b1;
                w_next_emg   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            r_state    <= NS_G;
            r_timer    <= '0;
            r_emg_mode <= 1'b0;
            r_pend_ns  <= 1'b0;
            r_pend_ew  <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_timer    <= w_timer_clr ? '0 : r_timer + 1'b1;
            r_emg_mode <= w_next_emg;
            r_pend_ns  <= (r_pend_ns & ~w_serve_ns) | emg_n_s;
            r_pend_ew  <= (r_pend_ew & ~w_serve_ew) | emg_e_w;
        end
    end

    always_comb begin
        n_s_light_out = LAMP_R;
        e_w_light_out = LAMP_R;
        case (r_state)
            NS_G:    n_s_light_out = LAMP_G;
            NS_Y:    n_s_light_out = LAMP_Y;
            EW_G:    e_w_light_out = LAMP_G;
            EW_Y:    e_w_light_out = LAMP_Y;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_t_c.sv
// Directed bench for t_c: walks normal cycling, emergency pre-emption, own-direction
// extension, simultaneous requests and reset during an emergency green.
module tb_t_c;

    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b100;

    logic       clk = 1'b0;
    logic       rst;
    logic       emg_n_s;
    logic       emg_e_w;
    logic [2:0] n_s_light_out;
    logic [2:0] e_w_light_out;

    int n_vec = 0;
    int n_err = 0;

    t_c #(
        .GREEN_CYCLES (20),
        .YELLOW_CYCLES(5),
        .EMG_CYCLES   (30)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .emg_n_s      (emg_n_s),
        .emg_e_w      (emg_e_w),
        .n_s_light_out(n_s_light_out),
        .e_w_light_out(e_w_light_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] ns, input logic [2:0] ew);
        n_vec++;
        assert ({n_s_light_out, e_w_light_out} === {ns, ew}) else begin
            n_err++;
            $error("FAIL %s: observed ns=%b ew=%b, expected ns=%b ew=%b",
                   tag, n_s_light_out, e_w_light_out, ns, ew);
        end
    endtask

    // Check the lamps on each of n consecutive cycles, advancing one clock after each.
    task automatic expect_run(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                              input int n);
        for (int i = 0; i < n; i++) begin
            check(tag, ns, ew);
            tick();
        end
    endtask

    initial begin
        rst     = 1'b1;
        emg_n_s = 1'b0;
        emg_e_w = 1'b0;
        tick();
        tick();
        check("reset_state", G, R);
        rst = 1'b0;

        // Two full normal cycles (100 clocks), then NS green again.
        for (int k = 0; k < 2; k++) begin
            expect_run("norm_ns_g", G, R, 20);
            expect_run("norm_ns_y", Y, R, 5);
            expect_run("norm_ew_g", R, G, 20);
            expect_run("norm_ew_y", R, Y, 5);
        end

        // NS request as a 2-cycle pulse starting at EW_G timer=5.
        expect_run("pre1_ns_g", G, R, 20);
        expect_run("pre1_ns_y", Y, R, 5);
        expect_run("pre1_ew_g", R, G, 5);
        emg_n_s = 1'b1;
        expect_run("pre1_ew_g_req", R, G, 2);
        emg_n_s = 1'b0;
        expect_run("pre1_ew_y", R, Y, 5);
        expect_run("pre1_ns_emg", G, R, 30);
        expect_run("pre1_ns_y2", Y, R, 5);
        expect_run("pre1_ew_norm", R, G, 20);
        expect_run("pre1_ew_y2", R, Y, 5);

        // EW request as a 1-cycle pulse at NS_G timer=3.
        expect_run("pre2_ns_g", G, R, 3);
        emg_e_w = 1'b1;
        expect_run("pre2_ns_g_req", G, R, 1);
        emg_e_w = 1'b0;
        expect_run("pre2_ns_g_last", G, R, 1);
        expect_run("pre2_ns_y", Y, R, 5);
        expect_run("pre2_ew_emg", R, G, 30);
        expect_run("pre2_ew_y", R, Y, 5);

        // NS request during its own green at timer=15: green restarts for 30.
        expect_run("ext_ns_g", G, R, 15);
        emg_n_s = 1'b1;
        expect_run("ext_ns_g_req", G, R, 1);
        emg_n_s = 1'b0;
        expect_run("ext_ns_g_pend", G, R, 1);
        expect_run("ext_ns_emg", G, R, 30);
        expect_run("ext_ns_y", Y, R, 5);

        // Both requests in the same cycle during a normal EW green.
        expect_run("both_ew_g", R, G, 2);
        emg_n_s = 1'b1;
        emg_e_w = 1'b1;
        expect_run("both_ew_g_req", R, G, 1);
        emg_n_s = 1'b0;
        emg_e_w = 1'b0;
        expect_run("both_ew_g_last", R, G, 1);
        expect_run("both_ew_y", R, Y, 5);
        expect_run("both_ns_emg", G, R, 30);
        expect_run("both_ns_y", Y, R, 5);
        expect_run("both_ew_emg", R, G, 10);

        // NS request latched under the EW emergency, then reset held for 5 edges.
        emg_n_s = 1'b1;
        expect_run("rst_ew_emg_req", R, G, 1);
        rst = 1'b1;
        expect_run("rst_ew_emg_last", R, G, 1);
        expect_run("rst_hold", G, R, 3);
        emg_n_s = 1'b0;
        expect_run("rst_hold_last", G, R, 1);
        rst = 1'b0;
        expect_run("post_rst_ns_g", G, R, 20);
        expect_run("post_rst_ns_y", Y, R, 5);
        check("post_rst_ew_g", R, G);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
